// File: rtl/i2c_slave_core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_core_pkg
// Purpose  : Shared state encoding, ACK/NACK bit levels and synchroniser depth
//            for the I2C slave core and its line synchroniser.
// Revision : 1.0 - initial release
// ============================================================================
package i2c_slave_core_pkg;

  // Protocol FSM states. Being disabled is not a state: it forces IDLE.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_WR_DATA  = 4'd3,
    ST_WR_ACK   = 4'd4,
    ST_RD_DATA  = 4'd5,
    ST_RD_ACK   = 4'd6,
    ST_IGNORE   = 4'd7
  } state_e;

  // Level of SDA during the acknowledge bit.
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Flops between a raw bus pin and the edge detector.
  localparam int SYNC_DEPTH = 2;

  // Byte put on the bus when a read starts with no data offered.
  localparam logic [7:0] RD_IDLE_BYTE = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/i2c_slave_line_sync.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_line_sync
// Purpose  : Synchronises raw SCL/SDA, detects SCL edges and START/STOP
//            conditions. Outputs are single-cycle pulses.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_line_sync
  import i2c_slave_core_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_DEPTH-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_DEPTH-1:0] sda_sync_q, sda_sync_d;
  logic                  scl_prev_q, scl_prev_d;
  logic                  sda_prev_q, sda_prev_d;
  logic                  scl_lvl;

  assign scl_lvl = scl_sync_q[SYNC_DEPTH-1];
  assign sda_o   = sda_sync_q[SYNC_DEPTH-1];

  // Shift the pin levels through the synchroniser and keep last synced level.
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_DEPTH-2:0], scl_i};
    sda_sync_d = {sda_sync_q[SYNC_DEPTH-2:0], sda_i};
    scl_prev_d = scl_lvl;
    sda_prev_d = sda_o;
  end

  // Idle bus is high, so everything resets to 1 to avoid a false edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign scl_rise_o = scl_lvl & ~scl_prev_q;
  assign scl_fall_o = ~scl_lvl & scl_prev_q;
  // SDA moving while SCL stays high is a bus condition, not data.
  assign start_o    = scl_lvl & scl_prev_q & ~sda_o & sda_prev_q;
  assign stop_o     = scl_lvl & scl_prev_q & sda_o & ~sda_prev_q;

endmodule
`default_nettype wire

// File: rtl/i2c_slave_core.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_core
// Purpose  : I2C slave protocol engine: address match, write bytes to an rx
//            sink, read bytes from a tx source, ACK/NACK generation.
// Config   : I2C_SLAVE_CLK_STRETCH_EN - hold SCL low while the tx source has
//            no data or the rx sink is full, instead of sending 0xFF / NACK.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_core
  import i2c_slave_core_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       i2c_core_clock_i,
  input  logic       reset_bit_i,
  input  logic       enable_bit_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_en_o,
  output logic       scl_en_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_full_i,
  output logic [7:0] addr_rw_o,
  output logic       busy_o
);

  logic sda_lvl, scl_rise, scl_fall, start_det, stop_det;

  i2c_slave_line_sync u_line_sync (
    .clk_i      (i2c_core_clock_i),
    .rst_i      (reset_bit_i),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_lvl),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;       // bits already received this byte
  logic [7:0]  tx_shift_q, tx_shift_d; // MSB is the next bit to drive
  logic        sda_en_q, sda_en_d;
  logic        ack_phase_q, ack_phase_d; // ACK bit in progress / master ACKed
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  addr_rw_q, addr_rw_d;
  logic        busy_q, busy_d;
  logic        tx_ready;
  logic        rd_start;
  logic [7:0]  rx_byte;

`ifdef I2C_SLAVE_CLK_STRETCH_EN
  logic        scl_en_q, scl_en_d;
  logic        rd_wait_q, rd_wait_d;   // stretching for tx data
  logic        wr_wait_q, wr_wait_d;   // stretching for rx space
`endif

  assign rx_byte = {shift_q, sda_lvl};

  // Next-state and datapath: enable, then START, then STOP beat SCL edges.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_shift_d  = tx_shift_q;
    sda_en_d    = sda_en_q;
    ack_phase_d = ack_phase_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    addr_rw_d   = addr_rw_q;
    busy_d      = busy_q;
    tx_ready    = 1'b0;
    rd_start    = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    scl_en_d    = 1'b0;
    rd_wait_d   = rd_wait_q;
    wr_wait_d   = wr_wait_q;
`endif

    if (!enable_bit_i) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = 3'd0;
      shift_d     = '0;
      sda_en_d    = 1'b0;
      ack_phase_d = 1'b0;
      busy_d      = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      rd_wait_d   = 1'b0;
      wr_wait_d   = 1'b0;
`endif
    end else if (start_det) begin
      state_d     = ST_ADDR;
      bit_cnt_d   = 3'd0;
      sda_en_d    = 1'b0;
      ack_phase_d = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      rd_wait_d   = 1'b0;
      wr_wait_d   = 1'b0;
`endif
    end else if (stop_det) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = 3'd0;
      sda_en_d    = 1'b0;
      ack_phase_d = 1'b0;
      busy_d      = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      rd_wait_d   = 1'b0;
      wr_wait_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_IGNORE: begin
          // only a bus condition leaves these states
        end

        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                addr_rw_d   = rx_byte;
                busy_d      = 1'b1;
                ack_phase_d = 1'b0;
                state_d     = ST_ADDR_ACK;
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              sda_en_d    = ~ACK;
              ack_phase_d = 1'b1;
            end else begin
              ack_phase_d = 1'b0;
              if (addr_rw_q[0]) begin
                rd_start = 1'b1;
              end else begin
                sda_en_d  = 1'b0;
                bit_cnt_d = 3'd0;
                state_d   = ST_WR_DATA;
              end
            end
          end
        end

        ST_WR_DATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d   = rx_byte;
              rx_valid_d  = 1'b1;
              ack_phase_d = 1'b0;
              state_d     = ST_WR_ACK;
            end
          end
        end

        ST_WR_ACK: begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
          if (wr_wait_q) begin
            // SDA settles to ACK one cycle before SCL is let go
            scl_en_d = 1'b1;
            if (!rx_full_i) begin
              sda_en_d    = ~ACK;
              ack_phase_d = 1'b1;
              wr_wait_d   = 1'b0;
            end
          end else if (scl_fall) begin
`else
          if (scl_fall) begin
`endif
            if (!ack_phase_q) begin
              if (!rx_full_i) begin
                sda_en_d    = ~ACK;
                ack_phase_d = 1'b1;
              end else begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                scl_en_d  = 1'b1;
                wr_wait_d = 1'b1;
`else
                sda_en_d  = ~NACK;
                state_d   = ST_IGNORE;
`endif
              end
            end else begin
              sda_en_d    = 1'b0;
              ack_phase_d = 1'b0;
              bit_cnt_d   = 3'd0;
              state_d     = ST_WR_DATA;
            end
          end
        end

        ST_RD_DATA: begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
          if (rd_wait_q) begin
            // keep SCL low through the load cycle so bit 7 is set up first
            tx_ready = 1'b1;
            scl_en_d = 1'b1;
            if (tx_valid_i) begin
              sda_en_d   = ~tx_data_i[7];
              tx_shift_d = {tx_data_i[6:0], 1'b1};
              rd_wait_d  = 1'b0;
            end
          end else if (scl_fall) begin
`else
          if (scl_fall) begin
`endif
            sda_en_d   = ~tx_shift_q[7];
            tx_shift_d = {tx_shift_q[6:0], 1'b1};
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ack_phase_d = 1'b0;
              state_d     = ST_RD_ACK;
            end
          end
        end

        ST_RD_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              sda_en_d = 1'b0;
            end else begin
              ack_phase_d = 1'b0;
              rd_start    = 1'b1;
            end
          end else if (scl_rise) begin
            if (sda_lvl == NACK) begin
              state_d = ST_IGNORE;
            end else begin
              ack_phase_d = 1'b1;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // Falling edge that opens a read byte: offer the handshake and load.
      if (rd_start) begin
        tx_ready  = 1'b1;
        bit_cnt_d = 3'd0;
        state_d   = ST_RD_DATA;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        if (tx_valid_i) begin
          sda_en_d   = ~tx_data_i[7];
          tx_shift_d = {tx_data_i[6:0], 1'b1};
        end else begin
          sda_en_d  = 1'b0;
          scl_en_d  = 1'b1;
          rd_wait_d = 1'b1;
        end
`else
        sda_en_d   = tx_valid_i ? ~tx_data_i[7] : ~RD_IDLE_BYTE[7];
        tx_shift_d = tx_valid_i ? {tx_data_i[6:0], 1'b1} : {RD_IDLE_BYTE[6:0], 1'b1};
`endif
      end
    end
  end

  // State register; reset releases the bus lines asynchronously.
  always_ff @(posedge i2c_core_clock_i or posedge reset_bit_i) begin
    if (reset_bit_i) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= '0;
      tx_shift_q  <= '1;
      sda_en_q    <= 1'b0;
      ack_phase_q <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      addr_rw_q   <= 8'h00;
      busy_q      <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      scl_en_q    <= 1'b0;
      rd_wait_q   <= 1'b0;
      wr_wait_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_shift_q  <= tx_shift_d;
      sda_en_q    <= sda_en_d;
      ack_phase_q <= ack_phase_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      addr_rw_q   <= addr_rw_d;
      busy_q      <= busy_d;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      scl_en_q    <= scl_en_d;
      rd_wait_q   <= rd_wait_d;
      wr_wait_q   <= wr_wait_d;
`endif
    end
  end

  assign sda_en_o   = sda_en_q;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
  assign scl_en_o   = scl_en_q;
`else
  assign scl_en_o   = 1'b0;
`endif
  assign tx_ready_o = tx_ready;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign addr_rw_o  = addr_rw_q;
  assign busy_o     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_core
// Purpose  : Directed bench for i2c_slave_core; a bus master is modelled with
//            tasks and open-drain wired lines.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_core;
  import i2c_slave_core_pkg::*;

  localparam int Q = 8; // core cycles per quarter of an SCL period

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       m_scl, m_sda;          // master outputs, 1 = released
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       rx_full;
  logic       scl_line, sda_line;
  logic       sda_en, scl_en, tx_ready, rx_valid, busy;
  logic [7:0] rx_data, addr_rw;

  int         checks = 0;
  int         errors = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_last = 8'h00;
  int         txr_cnt = 0;
  int         stretch_cnt = 0;

  always #5 clk = ~clk;

  assign scl_line = m_scl & ~scl_en;
  assign sda_line = m_sda & ~sda_en;

  i2c_slave_core #(.SLAVE_ADDR(7'h50)) dut (
    .i2c_core_clock_i (clk),
    .reset_bit_i      (rst),
    .enable_bit_i     (enable),
    .scl_i            (scl_line),
    .sda_i            (sda_line),
    .sda_en_o         (sda_en),
    .scl_en_o         (scl_en),
    .tx_data_i        (tx_data),
    .tx_valid_i       (tx_valid),
    .tx_ready_o       (tx_ready),
    .rx_data_o        (rx_data),
    .rx_valid_o       (rx_valid),
    .rx_full_i        (rx_full),
    .addr_rw_o        (addr_rw),
    .busy_o           (busy)
  );

  // Count handshake pulses and stretch cycles away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt  <= rx_cnt + 1;
      rx_last <= rx_data;
    end
    if (tx_ready) txr_cnt <= txr_cnt + 1;
    if (scl_en) stretch_cnt <= stretch_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_scl_high();
    int n = 0;
    while (scl_line !== 1'b1 && n < 400) begin
      cyc(1);
      n++;
    end
    if (n >= 400) chk("scl_release_timeout", {31'd0, scl_line}, 32'd1);
  endtask

  task automatic put_bit(input logic b);
    m_sda = b;
    cyc(Q);
    m_scl = 1'b1;
    cyc(1);
    wait_scl_high();
    cyc(Q);
    m_scl = 1'b0;
    cyc(Q);
  endtask

  task automatic get_bit(output logic b);
    m_sda = 1'b1;
    cyc(Q);
    m_scl = 1'b1;
    cyc(1);
    wait_scl_high();
    cyc(Q);
    b = sda_line;
    m_scl = 1'b0;
    cyc(Q);
  endtask

  task automatic put8(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    put8(d);
    get_bit(ack);
  endtask

  task automatic read8(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
  endtask

  task automatic bus_start();
    m_sda = 1'b1;
    cyc(Q);
    m_scl = 1'b1;
    cyc(Q);
    m_sda = 1'b0;
    cyc(Q);
    m_scl = 1'b0;
    cyc(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0;
    cyc(Q);
    m_scl = 1'b1;
    cyc(Q);
    m_sda = 1'b1;
    cyc(Q);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         base;

    rst = 1'b1; enable = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    tx_data = 8'h00; tx_valid = 1'b0; rx_full = 1'b0;
    cyc(3);

    // reset values
    chk("rst_sda_en",   {31'd0, sda_en},   32'd0);
    chk("rst_scl_en",   {31'd0, scl_en},   32'd0);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rx_data",  {24'd0, rx_data},  32'h00);
    chk("rst_addr_rw",  {24'd0, addr_rw},  32'h00);
    chk("rst_busy",     {31'd0, busy},     32'd0);
    chk("rst_state",    32'(dut.state_q),  32'(ST_IDLE));
    rst = 1'b0;
    cyc(4);

    // write A0, 3C, 81
    bus_start();
    write_byte(8'hA0, ack);
    chk("wr_addr_ack", {31'd0, ack}, 32'd0);
    chk("wr_addr_rw",  {24'd0, addr_rw}, 32'hA0);
    chk("wr_busy",     {31'd0, busy}, 32'd1);
    write_byte(8'h3C, ack);
    chk("wr_b1_ack",   {31'd0, ack}, 32'd0);
    chk("wr_b1_data",  {24'd0, rx_last}, 32'h3C);
    chk("wr_b1_cnt",   32'(rx_cnt), 32'd1);
    write_byte(8'h81, ack);
    chk("wr_b2_ack",   {31'd0, ack}, 32'd0);
    chk("wr_b2_data",  {24'd0, rx_last}, 32'h81);
    chk("wr_b2_cnt",   32'(rx_cnt), 32'd2);
    bus_stop();
    cyc(4);
    chk("wr_stop_busy",  {31'd0, busy}, 32'd0);
    chk("wr_stop_state", 32'(dut.state_q), 32'(ST_IDLE));

    // read 5A (master ACK) then C3 (master NACK)
    tx_data = 8'h5A; tx_valid = 1'b1;
    base = txr_cnt;
    bus_start();
    write_byte(8'hA1, ack);
    chk("rd_addr_ack", {31'd0, ack}, 32'd0);
    read8(d);
    chk("rd_b1", {24'd0, d}, 32'h5A);
    tx_data = 8'hC3;
    put_bit(ACK);
    read8(d);
    chk("rd_b2", {24'd0, d}, 32'hC3);
    put_bit(NACK);
    cyc(2);
    chk("rd_nack_state", 32'(dut.state_q), 32'(ST_IGNORE));
    chk("rd_tx_ready_cnt", 32'(txr_cnt - base), 32'd2);
    bus_stop();
    cyc(4);
    chk("rd_stop_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("rd_stop_busy",  {31'd0, busy}, 32'd0);

    // foreign address A4
    base = rx_cnt;
    bus_start();
    write_byte(8'hA4, ack);
    chk("miss_nack",    {31'd0, ack}, 32'd1);
    chk("miss_busy",    {31'd0, busy}, 32'd0);
    chk("miss_state",   32'(dut.state_q), 32'(ST_IGNORE));
    chk("miss_addr_rw", {24'd0, addr_rw}, 32'hA1);
    bus_stop();
    cyc(4);
    chk("miss_rx_cnt",  32'(rx_cnt - base), 32'd0);

    // write A0, 11, repeated START, A1
    bus_start();
    write_byte(8'hA0, ack);
    chk("rs_addr_rw0", {24'd0, addr_rw}, 32'hA0);
    write_byte(8'h11, ack);
    chk("rs_wr_ack",   {31'd0, ack}, 32'd0);
    chk("rs_wr_data",  {24'd0, rx_last}, 32'h11);
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    tx_data = 8'h5A; tx_valid = 1'b1;
`else
    tx_data = 8'h00; tx_valid = 1'b0;
`endif
    bus_start();
    write_byte(8'hA1, ack);
    chk("rs_rd_ack",   {31'd0, ack}, 32'd0);
    chk("rs_addr_rw1", {24'd0, addr_rw}, 32'hA1);
    chk("rs_state",    32'(dut.state_q), 32'(ST_RD_DATA));
    chk("rs_busy",     {31'd0, busy}, 32'd1);
    read8(d);
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    chk("rs_rd_byte",  {24'd0, d}, 32'h5A);
`else
    chk("rs_rd_idle_byte", {24'd0, d}, 32'hFF);
`endif
    put_bit(NACK);
    bus_stop();
    tx_valid = 1'b1;
    cyc(4);

    // rx sink full during the first data byte
    bus_start();
    write_byte(8'hA0, ack);
    rx_full = 1'b1;
    base = stretch_cnt;
    put8(8'h22);
    fork
      begin
        cyc(20);
        rx_full = 1'b0;
      end
    join_none
    get_bit(ack);
    chk("full_rx_data", {24'd0, rx_last}, 32'h22);
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    chk("full_ack",     {31'd0, ack}, 32'd0);
    chk("full_stretch", {31'd0, (stretch_cnt - base) >= 15}, 32'd1);
`else
    chk("full_nack",    {31'd0, ack}, 32'd1);
    chk("full_no_stretch", 32'(stretch_cnt - base), 32'd0);
`endif
    bus_stop();
    rx_full = 1'b0;
    cyc(4);

    // disable mid-read while the slave holds SDA low
    tx_data = 8'h00; tx_valid = 1'b1;
    bus_start();
    write_byte(8'hA1, ack);
    get_bit(ack);
    chk("dis_pre_sda_en", {31'd0, sda_en}, 32'd1);
    enable = 1'b0;
    cyc(2);
    chk("dis_sda_en", {31'd0, sda_en}, 32'd0);
    chk("dis_state",  32'(dut.state_q), 32'(ST_IDLE));
    chk("dis_busy",   {31'd0, busy}, 32'd0);
    enable = 1'b1;
    bus_stop();
    cyc(4);

    // asynchronous reset at bit 4 of a read byte
    bus_start();
    write_byte(8'hA1, ack);
    for (int i = 0; i < 4; i++) get_bit(ack);
    chk("arst_pre_sda_en", {31'd0, sda_en}, 32'd1);
    base = rx_cnt;
    #2 rst = 1'b1;
    #1;
    chk("arst_sda_en",   {31'd0, sda_en},   32'd0);
    chk("arst_scl_en",   {31'd0, scl_en},   32'd0);
    chk("arst_tx_ready", {31'd0, tx_ready}, 32'd0);
    chk("arst_busy",     {31'd0, busy},     32'd0);
    chk("arst_addr_rw",  {24'd0, addr_rw},  32'h00);
    chk("arst_rx_data",  {24'd0, rx_data},  32'h00);
    chk("arst_state",    32'(dut.state_q),  32'(ST_IDLE));
    cyc(3);
    rst = 1'b0;
    m_scl = 1'b1;
    cyc(Q);
    m_sda = 1'b1;
    cyc(Q);
    chk("arst_no_rx_valid", 32'(rx_cnt - base), 32'd0);
    chk("arst_final_state", 32'(dut.state_q), 32'(ST_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_slave_core.md
I2C_SLAVE_CORE -- requirements
Module: i2c_slave_core

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50, the 7-bit address this slave responds to.
REQ-002 SHALL have ports: i2c_core_clock_i  in  1  core clock; all logic is on its rising edge.
REQ-003 reset_bit_i  in  1  reset, asynchronous and active-high.
REQ-004 enable_bit_i  in  1  when 0, the slave ignores the bus and releases SDA and SCL.
REQ-005 scl_i, sda_i  in  1 each  raw bus line levels (asynchronous).
REQ-006 sda_en_o  out  1  1 = pull SDA low; 0 = release.
REQ-007 scl_en_o  out  1  1 = pull SCL low for clock stretching; tied to 0 when stretching is compiled out.
REQ-008 tx_data_i  in  8, tx_valid_i  in  1, tx_ready_o  out  1  read-data source; a byte transfers when tx_valid_i and tx_ready_o are both high in the same cycle.
REQ-009 rx_data_o  out  8, rx_valid_o  out  1  received write byte, with a one-cycle valid pulse.
REQ-010 rx_full_i  in  1  the receive sink cannot accept a byte.
REQ-011 addr_rw_o  out  8  last matched address byte; busy_o  out  1  high from an address match until STOP.

Function
REQ-012 SHALL pass scl_i and sda_i through a 2-FF synchroniser, then a 1-FF edge detector, giving 3 cycles from pin change to detected event.
REQ-013 START SHALL be detected when SDA falls while SCL is high, and STOP when SDA rises while SCL is high.
REQ-014 START SHALL be acted on in any state except DISABLED, and SHALL go to ADDR (repeated start). STOP SHALL go to IDLE, release the bus and clear busy_o.
REQ-015 States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-016 Bits SHALL be sampled on the detected SCL rising edge. sda_en_o SHALL change only in the cycle after a detected SCL falling edge.
REQ-017 Bytes SHALL be shifted MSB first; a 3-bit counter SHALL count 0..7 and wrap to 0 at each ACK phase.
REQ-018 ADDR: after 8 bits, a match of bits[7:1] with SLAVE_ADDR SHALL load addr_rw_o, set busy_o and go to ADDR_ACK, which drives SDA low for one SCL period. A mismatch SHALL go to IGNORE, which waits for START or STOP.
REQ-019 After ADDR_ACK: R/W=0 SHALL go to WR_DATA; R/W=1 SHALL go to RD_DATA.
REQ-020 WR_DATA: after the 8th bit, rx_data_o SHALL update and rx_valid_o SHALL pulse for exactly 1 cycle; WR_ACK then SHALL ACK if rx_full_i=0 and NACK otherwise. NACK SHALL go to IGNORE; ACK SHALL return to WR_DATA.
REQ-021 RD_DATA: tx_ready_o SHALL assert for 1 cycle at the falling edge that starts each byte. If tx_valid_i=0 in that cycle, 8'hFF SHALL be sent (non-stretch build).
REQ-022 RD_ACK SHALL release SDA and sample the master's bit: ACK returns to RD_DATA; NACK goes to IGNORE.
REQ-023 A START/STOP that arrives in the same cycle as an SCL edge SHALL take priority over the edge.
REQ-024 enable_bit_i=0 SHALL force IDLE next cycle, release the bus and discard any partial byte.

Reset
REQ-025 Reset SHALL give: state IDLE, sda_en_o=0, scl_en_o=0, tx_ready_o=0, rx_valid_o=0, rx_data_o=8'h00, addr_rw_o=8'h00, busy_o=0, and synchronisers all 1.
REQ-026 Reset asserted mid-transfer SHALL release SDA/SCL asynchronously, and no rx_valid_o pulse SHALL follow.

Configuration
REQ-027 Macro I2C_SLAVE_CLK_STRETCH_EN, when defined, SHALL enable clock stretching:
- RD_DATA with tx_valid_i=0: SCL is held low after the falling edge, tx_ready_o is held high until the handshake, then SCL is released.
- WR_ACK with rx_full_i=1: SCL is held low until rx_full_i=0, then ACK (never NACK).
REQ-028 With the macro undefined, scl_en_o SHALL be constant 0 and REQ-020/021 fallbacks SHALL apply.

Structure
REQ-029 A shared package SHALL hold the state encoding constants, the ACK=0/NACK=1 constants and the synchroniser depth (2).
REQ-030 Sub-module i2c_slave_line_sync SHALL contain the synchronisers, edge detection and START/STOP detection; the FSM and shift register SHALL stay in i2c_slave_core.

Verification
REQ-031 Write 0xA0, then 0x3C and 0x81, with rx_full_i=0 -> ACK on all three bytes; rx_data_o=0x3C then 0x81, each with one rx_valid_o pulse; busy_o falls after STOP.
REQ-032 Write 0xA1 with tx 0x5A then 0xC3, master ACK then NACK -> bus shows 0x5A, 0xC3; tx_ready_o pulses twice; state is IGNORE then IDLE after STOP.
REQ-033 Address 0xA4 -> SDA released on the ACK bit (NACK); no rx_valid_o; busy_o stays 0.
REQ-034 Write 0xA0, 0x11, then repeated START, 0xA1 -> addr_rw_o=0xA1; RD_DATA entered without an intervening STOP.
REQ-035 rx_full_i=1 during byte 2 -> NACK (non-stretch build); stretch build: SCL held low for 20 cycles until rx_full_i=0, then ACK.
REQ-036 Reset asserted at bit 4 of a data byte -> sda_en_o=0 and scl_en_o=0 immediately; all outputs at REQ-025 values.
